// File: rtl/approx_mac_pipe.sv
// Three-stage pipelined approximate multiply-accumulate with valid/ready handshake.
// Low partial-product columns are dropped before summation to trade accuracy for area.
module approx_mac_pipe #(
    parameter int WIDTH       = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int APPROX_COLS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [ACC_WIDTH-1:0] c,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] r,
    output logic                 ovf
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << APPROX_COLS;

    typedef enum logic [1:0] {
        MODE_MAD     = 2'b00,
        MODE_ACC     = 2'b01,
        MODE_LOAD    = 2'b10,
        MODE_MAD_ALT = 2'b11
    } mode_t;

    logic                 en;
    logic                 s1_valid;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;
    logic [ACC_WIDTH-1:0] s1_c;
    mode_t                s1_mode;
    logic                 s2_valid;
    logic [PW-1:0]        s2_p;
    logic [ACC_WIDTH-1:0] s2_c;
    mode_t                s2_mode;
    logic [ACC_WIDTH-1:0] acc;
    logic [PW-1:0]        prod;
    logic [PW-1:0]        row;
    logic [ACC_WIDTH-1:0] opnd;
    logic [ACC_WIDTH:0]   sum;

    // A single global enable stalls every stage whenever the output is held.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Each row of the partial-product array is masked so only columns at or
    // above APPROX_COLS contribute; the kept bits are then summed exactly.
    always_comb begin
        prod = '0;
        row  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row = '0;
            if (s1_b[i]) begin
                row = PW'(s1_a) << i;
            end
            prod = prod + (row & KEEP_MASK);
        end
    end

    always_comb begin
        opnd = (s2_mode == MODE_ACC) ? acc : s2_c;
        sum  = {1'b0, opnd} + {1'b0, ACC_WIDTH'(s2_p)};
    end

    // Data registers carry no reset; only valid bits, acc and the result are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            r         <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_a      <= a;
            s1_b      <= b;
            s1_c      <= c;
            s1_mode   <= mode_t'(mode);
            s2_valid  <= s1_valid;
            s2_p      <= prod;
            s2_c      <= s1_c;
            s2_mode   <= s1_mode;
            out_valid <= s2_valid;
            if (s2_valid) begin
                r   <= sum[ACC_WIDTH-1:0];
                ovf <= sum[ACC_WIDTH];
                if (s2_mode == MODE_ACC || s2_mode == MODE_LOAD) begin
                    acc <= sum[ACC_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_mac_pipe.sv
// Self-checking bench for approx_mac_pipe: an exact and a truncating instance share
// stimulus and are each compared against an arithmetic reference model.
module tb_approx_mac_pipe;

    typedef struct packed {
        logic [39:0] r;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [39:0] c;
    logic [1:0]  mode;

    logic        in_ready0, out_valid0, ovf0;
    logic [39:0] r0;
    logic        in_ready1, out_valid1, ovf1;
    logic [39:0] r1;

    res_t        q0[$];
    res_t        q1[$];
    logic [39:0] acc0, acc1;
    logic [39:0] last_r0;
    logic [39:0] held_r0, held_r1;
    logic        stall_prev;
    logic        last_accept;
    int          checks;
    int          passed;
    int          nout;

    approx_mac_pipe #(.WIDTH(16), .ACC_WIDTH(40), .APPROX_COLS(0)) dut_exact (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .c(c), .mode(mode),
        .out_valid(out_valid0), .out_ready(out_ready), .r(r0), .ovf(ovf0)
    );

    approx_mac_pipe #(.WIDTH(16), .ACC_WIDTH(40), .APPROX_COLS(12)) dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .c(c), .mode(mode),
        .out_valid(out_valid1), .out_ready(out_ready), .r(r1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] approxProd(input logic [15:0] x, input logic [15:0] y,
                                               input int cols);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (i + j >= cols && x[j] && y[i]) begin
                    s = s + (32'd1 << (i + j));
                end
            end
        end
        return s;
    endfunction

    function automatic res_t modelTxn(input logic [15:0] x, input logic [15:0] y,
                                      input logic [39:0] z, input logic [1:0] m,
                                      input int cols, inout logic [39:0] acc_m);
        logic [40:0] total;
        logic [39:0] p;
        res_t        res;
        p = 40'(approxProd(x, y, cols));
        if (m == 2'b01) total = {1'b0, acc_m} + {1'b0, p};
        else            total = {1'b0, z} + {1'b0, p};
        if (m == 2'b01 || m == 2'b10) acc_m = total[39:0];
        res.r   = total[39:0];
        res.ovf = total[40];
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive at the falling edge, judge transfers just before the rising edge.
    task automatic applyStimulus(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                                 input logic [39:0] ic, input logic [1:0] im, input logic ordy);
        res_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        c         = ic;
        mode      = im;
        out_ready = ordy;
        #1;
        if (stall_prev) begin
            checkOutput("hold_valid", 64'(out_valid0), 64'd1);
            checkOutput("hold_r_exact", 64'(r0), 64'(held_r0));
            checkOutput("hold_r_trunc", 64'(r1), 64'(held_r1));
        end
        if (out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                checkOutput("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = q0.pop_front();
                checkOutput("r_exact", 64'(r0), 64'(e.r));
                checkOutput("ovf_exact", 64'(ovf0), 64'(e.ovf));
                last_r0 = e.r;
                e = q1.pop_front();
                checkOutput("valid_trunc", 64'(out_valid1), 64'd1);
                checkOutput("r_trunc", 64'(r1), 64'(e.r));
                checkOutput("ovf_trunc", 64'(ovf1), 64'(e.ovf));
            end
            nout = nout + 1;
        end
        last_accept = iv && in_ready0;
        if (last_accept) begin
            q0.push_back(modelTxn(ia, ib, ic, im, 0, acc0));
            q1.push_back(modelTxn(ia, ib, ic, im, 12, acc1));
        end
        stall_prev = out_valid0 && !out_ready;
        held_r0    = r0;
        held_r1    = r1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        acc0       = '0;
        acc1       = '0;
        last_r0    = '0;
        stall_prev = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid0), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready0), 64'd1);
        checkOutput("rst_r", 64'(r0), 64'd0);
        checkOutput("rst_ovf", 64'(ovf0), 64'd0);
        checkOutput("rst_trunc_valid", 64'(out_valid1), 64'd0);
        checkOutput("rst_trunc_ready", 64'(in_ready1), 64'd1);
    endtask

    task automatic send(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                        input logic [39:0] z);
        applyStimulus(1'b1, x, y, z, m, 1'b1);
        checkOutput("send_accept", 64'(last_accept), 64'd1);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (q0.size() != 0 && guard < 12) begin
            applyStimulus(1'b0, 16'd0, 16'd0, 40'd0, 2'b00, 1'b1);
            guard++;
        end
        checkOutput({tag, "_drained"}, 64'(q0.size()), 64'd0);
        checkOutput({tag, "_idle_valid"}, 64'(out_valid0), 64'd0);
        checkOutput({tag, "_idle_r"}, 64'(r0), 64'(last_r0));
    endtask

    initial begin
        int          k;
        int          g;
        int          n_before;
        logic [63:0] rnd;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c         = '0;
        mode      = '0;
        checks    = 0;
        passed    = 0;
        nout      = 0;
        acc0      = '0;
        acc1      = '0;
        last_r0   = '0;
        held_r0   = '0;
        held_r1   = '0;
        stall_prev  = 1'b0;
        last_accept = 1'b0;
        @(negedge clk);
        doReset();

        // Latency: the result appears exactly three cycles after the input transfer.
        send(2'b00, 16'd3, 16'd5, 40'd7);
        checkOutput("lat_t1", 64'(out_valid0), 64'd0);
        applyStimulus(1'b0, 16'd0, 16'd0, 40'd0, 2'b00, 1'b1);
        checkOutput("lat_t2", 64'(out_valid0), 64'd0);
        applyStimulus(1'b0, 16'd0, 16'd0, 40'd0, 2'b00, 1'b1);
        #1;
        checkOutput("lat_t3_valid", 64'(out_valid0), 64'd1);
        checkOutput("lat_r", 64'(r0), 64'd22);
        checkOutput("lat_ovf", 64'(ovf0), 64'd0);
        drain("lat");

        send(2'b00, 16'h0040, 16'h0040, 40'd0);
        send(2'b00, 16'h0020, 16'h0040, 40'd0);
        drain("trunc");

        send(2'b10, 16'd2, 16'd3, 40'd10);
        send(2'b01, 16'd4, 16'd4, 40'd999);
        send(2'b01, 16'd1, 16'd1, 40'd0);
        send(2'b00, 16'd1, 16'd1, 40'd0);
        send(2'b01, 16'd1, 16'd1, 40'd0);
        send(2'b11, 16'd5, 16'd5, 40'd1);
        drain("accum");

        send(2'b00, 16'hFFFF, 16'hFFFF, 40'hFF_FFFF_FFFF);
        send(2'b10, 16'hFFFF, 16'hFFFF, 40'hFF_FFFF_FFFF);
        drain("ovf");

        // Backpressure: only three transactions fit while the output is blocked.
        k = 0;
        for (int s = 0; s < 6; s++) begin
            applyStimulus(1'b1, 16'(k + 1), 16'd3, 40'(100 * k), 2'b00, 1'b0);
            if (last_accept) k++;
        end
        checkOutput("bp_accepted", 64'(k), 64'd3);
        n_before = nout;
        g = 0;
        while (k < 5 && g < 20) begin
            applyStimulus(1'b1, 16'(k + 1), 16'd3, 40'(100 * k), 2'b00, 1'b1);
            if (last_accept) k++;
            g++;
        end
        drain("bp");
        checkOutput("bp_count", 64'(nout - n_before), 64'd5);

        // Reset with acc=33 and three transactions in flight discards all of them.
        send(2'b10, 16'd1, 16'd1, 40'd32);
        drain("preload");
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b1, 16'd7, 16'd7, 40'd1, 2'b01, 1'b0);
        end
        doReset();
        send(2'b01, 16'd1, 16'd1, 40'd0);
        drain("post_rst");

        for (int s = 0; s < 400; s++) begin
            rnd = {$urandom(), $urandom()};
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom()), 16'($urandom()),
                          rnd[39:0], 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end
        drain("rand");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
